// File: rtl/cmos_pkg.sv
// Shared types and slot-placement helper for the CMOS pixel packer.
package cmos_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bit offset of beat slot k inside the packed word; swap puts the first beat in the LSBs.
   function automatic int slot_lsb(input int k, input logic swap, input int in_w, input int ratio);
      return swap ? (k * in_w) : ((ratio - 1 - k) * in_w);
   endfunction

endpackage

// File: rtl/cmos_sync_edge.sv
// Registers a level and flags its rising and falling transitions against the registered copy.
module cmos_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic q;

   always_ff @(posedge clk) begin
      if (rst) q <= 1'b0;
      else     q <= d;
   end

   assign rise = d & ~q;
   assign fall = q & ~d;

endmodule

// File: rtl/cmos_pixel_pack.sv
// Packs RATIO sensor beats into one word per strobe, with frame arming, byte order, markers and line counts.
module cmos_pixel_pack
   import cmos_pkg::*;
#(
   parameter int IN_W   = 8,
   parameter int RATIO  = 2,
   parameter bit VS_POL = 1'b1,
   parameter int LINE_W = 12
) (
   input  logic                  pclk,
   input  logic                  rst,
   input  logic                  vs_i,
   input  logic                  de_i,
   input  logic [IN_W-1:0]       pdata_i,
   input  logic                  swap_i,
   output logic                  de_o,
   output logic [IN_W*RATIO-1:0] pdata_o,
   output logic                  sof_o,
   output logic                  eol_o,
   output logic                  err_o,
   output logic [LINE_W-1:0]     line_cnt_o,
   output logic [LINE_W-1:0]     frame_lines_o
);

   localparam int OUT_W = IN_W * RATIO;
   localparam int BW    = $clog2(RATIO);
   localparam int OW    = $clog2(OUT_W);
   localparam logic [BW-1:0] BLAST = BW'(RATIO - 1);

   state_t           state, state_nxt;
   logic             run;
   logic             vs_act, vs_rise, vs_fall, de_rise, de_fall;
   logic             unused_edges;
   logic [BW-1:0]    bcnt;
   logic             swap_q;
   logic             sof_pend;
   logic [OUT_W-1:0] word, word_nxt;
   logic [OW-1:0]    slot_off;

   assign vs_act = VS_POL ? vs_i : ~vs_i;

   cmos_sync_edge u_vs_edge (
      .clk  (pclk),
      .rst  (rst),
      .d    (vs_act),
      .rise (vs_rise),
      .fall (vs_fall)
   );

   cmos_sync_edge u_de_edge (
      .clk  (pclk),
      .rst  (rst),
      .d    (de_i),
      .rise (de_rise),
      .fall (de_fall)
   );

   assign unused_edges = vs_fall | de_rise;

   always_ff @(posedge pclk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Arming is one-way; only reset brings the block back to IDLE.
   always_comb begin
      state_nxt = state;
      if (state == IDLE && vs_rise) state_nxt = RUN;
   end

   always_comb begin
      run = (state == RUN);
   end

   always_comb begin
      word_nxt = word;
      slot_off = OW'(slot_lsb(int'(bcnt), swap_q, IN_W, RATIO));
      word_nxt[slot_off +: IN_W] = pdata_i;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         de_o          <= 1'b0;
         sof_o         <= 1'b0;
         eol_o         <= 1'b0;
         err_o         <= 1'b0;
         pdata_o       <= '0;
         line_cnt_o    <= '0;
         frame_lines_o <= '0;
         bcnt          <= '0;
         swap_q        <= 1'b0;
         sof_pend      <= 1'b0;
         word          <= '0;
      end else begin
         de_o  <= 1'b0;
         sof_o <= 1'b0;
         eol_o <= 1'b0;
         err_o <= 1'b0;
         // A frame boundary overrides a coincident line end: no error, counter cleared.
         if (vs_rise) begin
            bcnt          <= '0;
            word          <= '0;
            frame_lines_o <= line_cnt_o;
            line_cnt_o    <= '0;
            swap_q        <= swap_i;
            sof_pend      <= 1'b1;
            eol_o         <= run & de_fall;
         end else if (run) begin
            if (de_fall) begin
               eol_o <= 1'b1;
               err_o <= (bcnt != '0);
               bcnt  <= '0;
               word  <= '0;
               if (line_cnt_o != '1) line_cnt_o <= line_cnt_o + 1'b1;
            end else if (de_i) begin
               if (bcnt == BLAST) begin
                  bcnt     <= '0;
                  word     <= '0;
                  de_o     <= 1'b1;
                  pdata_o  <= word_nxt;
                  sof_o    <= sof_pend;
                  sof_pend <= 1'b0;
               end else begin
                  bcnt <= bcnt + 1'b1;
                  word <= word_nxt;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cmos_pixel_pack.sv
// Bench driving a RATIO=2 and a RATIO=3 packer with identical beats against a queue-based model.
module tb_cmos_pixel_pack;

   logic       pclk = 1'b0;
   logic       rst, vs, de, swap;
   logic [7:0] pd;

   logic        de0, sof0, eol0, err0;
   logic [15:0] pdo0;
   logic [11:0] lc0, fl0;
   logic        de1, sof1, eol1, err1;
   logic [23:0] pdo1;
   logic [11:0] lc1, fl1;

   int checks = 0;
   int errors = 0;

   always #5 pclk = ~pclk;

   cmos_pixel_pack #(.IN_W(8), .RATIO(2), .VS_POL(1'b1), .LINE_W(12)) u_dut2 (
      .pclk(pclk), .rst(rst), .vs_i(vs), .de_i(de), .pdata_i(pd), .swap_i(swap),
      .de_o(de0), .pdata_o(pdo0), .sof_o(sof0), .eol_o(eol0), .err_o(err0),
      .line_cnt_o(lc0), .frame_lines_o(fl0)
   );

   cmos_pixel_pack #(.IN_W(8), .RATIO(3), .VS_POL(1'b1), .LINE_W(12)) u_dut3 (
      .pclk(pclk), .rst(rst), .vs_i(vs), .de_i(de), .pdata_i(pd), .swap_i(swap),
      .de_o(de1), .pdata_o(pdo1), .sof_o(sof1), .eol_o(eol1), .err_o(err1),
      .line_cnt_o(lc1), .frame_lines_o(fl1)
   );

   // Model: beats collect in a list; a full list becomes a word by shifted sums.
   bit     m_armed [2];
   bit     m_swap  [2];
   bit     m_sofp  [2];
   int     m_nq    [2];
   int     m_beats [2][4];
   int     m_lc    [2];
   int     m_fl    [2];
   bit     x_de    [2];
   bit     x_sof   [2];
   bit     x_eol   [2];
   bit     x_err   [2];
   longint x_pd    [2];
   bit     m_vsq, m_deq;

   always @(posedge pclk) begin
      int r;
      bit bnd, fell;
      longint w;
      bnd  = vs && !m_vsq;
      fell = m_deq && !de;
      for (int i = 0; i < 2; i++) begin
         r = (i == 0) ? 2 : 3;
         x_de[i] = 0; x_sof[i] = 0; x_eol[i] = 0; x_err[i] = 0;
         if (rst) begin
            m_armed[i] = 0; m_swap[i] = 0; m_sofp[i] = 0; m_nq[i] = 0;
            m_lc[i] = 0; m_fl[i] = 0; x_pd[i] = 0;
         end else if (bnd) begin
            x_eol[i] = m_armed[i] && fell;
            m_armed[i] = 1; m_nq[i] = 0; m_fl[i] = m_lc[i]; m_lc[i] = 0;
            m_swap[i] = swap; m_sofp[i] = 1;
         end else if (m_armed[i]) begin
            if (fell) begin
               x_eol[i] = 1;
               x_err[i] = (m_nq[i] != 0);
               m_nq[i] = 0;
               if (m_lc[i] < 4095) m_lc[i]++;
            end else if (de) begin
               m_beats[i][m_nq[i]] = int'(pd);
               m_nq[i]++;
               if (m_nq[i] == r) begin
                  w = 0;
                  for (int k = 0; k < r; k++)
                     w += longint'(m_beats[i][k]) << (m_swap[i] ? 8 * k : 8 * (r - 1 - k));
                  x_de[i] = 1; x_pd[i] = w; x_sof[i] = m_sofp[i]; m_sofp[i] = 0; m_nq[i] = 0;
               end
            end
         end
      end
      if (rst) begin
         m_vsq = 0; m_deq = 0;
      end else begin
         m_vsq = vs; m_deq = de;
      end
   end

   longint cap_w0[$], cap_w1[$];
   bit     cap_s0[$], cap_s1[$];
   int     n_err[2], n_eol[2];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_inst(input int i, input logic d, input logic s, input logic e, input logic er,
                           input longint p, input logic [11:0] lc, input logic [11:0] fl);
      chk($sformatf("de_o[r%0d]", i + 2), longint'(d), longint'(x_de[i]));
      chk($sformatf("sof_o[r%0d]", i + 2), longint'(s), longint'(x_sof[i]));
      chk($sformatf("eol_o[r%0d]", i + 2), longint'(e), longint'(x_eol[i]));
      chk($sformatf("err_o[r%0d]", i + 2), longint'(er), longint'(x_err[i]));
      chk($sformatf("pdata_o[r%0d]", i + 2), p, x_pd[i]);
      chk($sformatf("line_cnt_o[r%0d]", i + 2), longint'(lc), longint'(m_lc[i]));
      chk($sformatf("frame_lines_o[r%0d]", i + 2), longint'(fl), longint'(m_fl[i]));
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
      chk_inst(0, de0, sof0, eol0, err0, longint'(pdo0), lc0, fl0);
      chk_inst(1, de1, sof1, eol1, err1, longint'(pdo1), lc1, fl1);
      if (de0 === 1'b1) begin cap_w0.push_back(longint'(pdo0)); cap_s0.push_back(sof0); end
      if (de1 === 1'b1) begin cap_w1.push_back(longint'(pdo1)); cap_s1.push_back(sof1); end
      if (err0 === 1'b1) n_err[0]++;
      if (err1 === 1'b1) n_err[1]++;
      if (eol0 === 1'b1) n_eol[0]++;
      if (eol1 === 1'b1) n_eol[1]++;
   endtask

   task automatic cyc(input logic v, input logic d, input logic [7:0] p);
      vs = v; de = d; pd = p;
      tick();
   endtask

   task automatic send_line(input int n, input logic [7:0] first, input logic [7:0] step);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, first + 8'(k) * step);
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic boundary();
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic clear_caps();
      cap_w0.delete(); cap_w1.delete(); cap_s0.delete(); cap_s1.delete();
      n_err = '{0, 0}; n_eol = '{0, 0};
   endtask

   initial begin
      rst = 1'b1; vs = 1'b0; de = 1'b0; pd = 8'h00; swap = 1'b0;
      repeat (3) tick();
      chk("reset_pdata", longint'(pdo0), 0);
      rst = 1'b0;

      // Unarmed: beats without any vsync edge produce nothing.
      clear_caps();
      send_line(4, 8'h12, 8'h22);
      chk("unarmed_words", longint'(cap_w0.size() + cap_w1.size()), 0);
      chk("unarmed_lines", longint'(lc0), 0);

      // Normal order.
      boundary();
      clear_caps();
      send_line(4, 8'h12, 8'h22);
      chk("msb_nwords", longint'(cap_w0.size()), 2);
      if (cap_w0.size() == 2) begin
         chk("msb_w0", cap_w0[0], 64'h1234);
         chk("msb_sof0", longint'(cap_s0[0]), 1);
         chk("msb_w1", cap_w0[1], 64'h5678);
         chk("msb_sof1", longint'(cap_s0[1]), 0);
      end
      chk("msb_lines", longint'(lc0), 1);
      chk("msb_eol", longint'(n_eol[0]), 1);
      chk("r3_nwords", longint'(cap_w1.size()), 1);
      if (cap_w1.size() == 1) chk("r3_w0", cap_w1[0], 64'h123456);
      chk("r3_err", longint'(n_err[1]), 1);
      chk("r2_noerr", longint'(n_err[0]), 0);

      // Swapped order, then a mid-frame swap change that must be ignored.
      swap = 1'b1;
      boundary();
      clear_caps();
      send_line(4, 8'h12, 8'h22);
      chk("lsb_nwords", longint'(cap_w0.size()), 2);
      if (cap_w0.size() == 2) begin
         chk("lsb_w0", cap_w0[0], 64'h3412);
         chk("lsb_w1", cap_w0[1], 64'h7856);
      end
      if (cap_w1.size() == 1) chk("lsb_r3_w0", cap_w1[0], 64'h563412);
      else chk("lsb_r3_nwords", longint'(cap_w1.size()), 1);
      swap = 1'b0;
      clear_caps();
      send_line(4, 8'h12, 8'h22);
      if (cap_w0.size() == 2) begin
         chk("held_swap_w0", cap_w0[0], 64'h3412);
         chk("held_swap_sof", longint'(cap_s0[0]), 0);
      end else chk("held_swap_nwords", longint'(cap_w0.size()), 2);

      // Seven beats into RATIO=3: two words, then a partial-word error.
      boundary();
      clear_caps();
      send_line(7, 8'h01, 8'h01);
      chk("r3_7_nwords", longint'(cap_w1.size()), 2);
      if (cap_w1.size() == 2) begin
         chk("r3_7_w0", cap_w1[0], 64'h010203);
         chk("r3_7_w1", cap_w1[1], 64'h040506);
      end
      chk("r3_7_err", longint'(n_err[1]), 1);
      chk("r3_7_eol", longint'(n_eol[1]), 1);
      chk("r2_7_err", longint'(n_err[0]), 1);
      send_line(3, 8'hA1, 8'h01);
      if (cap_w1.size() == 3) chk("r3_slot0", cap_w1[2], 64'hA1A2A3);
      else chk("r3_slot0_nwords", longint'(cap_w1.size()), 3);

      // Four-line frame, then a boundary reports it.
      boundary();
      repeat (4) send_line(2, 8'h10, 8'h01);
      chk("four_lines", longint'(lc0), 4);
      boundary();
      chk("frame_lines", longint'(fl0), 4);
      chk("frame_lines_r3", longint'(fl1), 4);
      chk("line_cnt_clr", longint'(lc0), 0);

      // Boundary coincident with a line end on a partial word.
      clear_caps();
      cyc(1'b0, 1'b1, 8'hAA);
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("coinc_err", longint'(n_err[0] + n_err[1]), 0);
      chk("coinc_eol", longint'(n_eol[0]), 1);
      chk("coinc_lines", longint'(lc0), 0);

      // Reset mid-word disarms the block.
      boundary();
      cyc(1'b0, 1'b1, 8'h11);
      rst = 1'b1;
      cyc(1'b0, 1'b1, 8'h22);
      rst = 1'b0;
      chk("rst_de", longint'(de0), 0);
      chk("rst_pdata", longint'(pdo0), 0);
      chk("rst_fl", longint'(fl0), 0);
      clear_caps();
      send_line(4, 8'h12, 8'h22);
      chk("rst_unarmed", longint'(cap_w0.size() + cap_w1.size()), 0);
      boundary();
      send_line(2, 8'h55, 8'h01);
      chk("rearm_nwords", longint'(cap_w0.size()), 1);
      if (cap_w0.size() == 1) begin
         chk("rearm_w0", cap_w0[0], 64'h5556);
         chk("rearm_sof", longint'(cap_s0[0]), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmos_pixel_pack.md
# cmos_pixel_pack

Parametrised successor to the team's 8→16-bit CMOS byte packer, running on the sensor pixel clock only, with no derived clock. Packs `RATIO` consecutive `IN_W`-bit sensor beats into one `OUT_W = IN_W*RATIO` word and emits a one-cycle valid strobe per word. Also provides:
- frame arming on vsync,
- a runtime byte-order mode,
- start-of-frame and end-of-line markers,
- partial-word error detection,
- a per-frame line count.

It sits between the DVP capture pins and the frame-buffer write path.

## Interface
Parameters:
- `IN_W`, 8, sensor data width per beat.
- `RATIO`, 2, beats per output word; legal range 2..4.
- `VS_POL`, 1, active level of `vs_i`; a frame boundary is the inactive→active transition.
- `LINE_W`, 12, width of the line counters.

Ports:
- `pclk`  in  1  sensor pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `vs_i`  in  1  sensor vsync.
- `de_i`  in  1  sensor data enable (href).
- `pdata_i`  in  IN_W  sensor data beat.
- `swap_i`  in  1  byte order: 0 = first beat in MSBs, 1 = first beat in LSBs.
- `de_o`  out  1  one-cycle strobe; `pdata_o` is valid.
- `pdata_o`  out  IN_W*RATIO  packed word.
- `sof_o`  out  1  high together with `de_o` on the first word of a frame.
- `eol_o`  out  1  one-cycle pulse when a line ends.
- `err_o`  out  1  one-cycle pulse when a line ends with a partial word.
- `line_cnt_o`  out  LINE_W  lines completed in the current frame.
- `frame_lines_o`  out  LINE_W  line count of the previous frame.

## Operation
- States: IDLE (unarmed) and RUN.
  - Reset enters IDLE.
  - IDLE→RUN on the first frame boundary after reset.
  - There is no return to IDLE except through reset.
  - In IDLE, all inputs are ignored and all outputs stay at their reset values.
- Frame boundary detection: `vs_i` is registered once. A boundary is detected when the registered value is inactive and the current `vs_i` is active.
- Frame boundary actions:
  - clear the beat counter and any partial word;
  - copy `line_cnt_o` into `frame_lines_o`, then clear `line_cnt_o`;
  - latch `swap_i` into `swap_q`;
  - set `sof_pend`.
  - `swap_i` has no effect except at a boundary.
- Beat counter `bcnt` (0..RATIO-1) advances on each `de_i`=1 beat in RUN and wraps to 0 on the completing beat.
- Each accepted beat is stored into slot `bcnt` of the word:
  - `swap_q`=0: slot k occupies bits [OUT_W-1-k·IN_W -: IN_W].
  - `swap_q`=1: slot k occupies bits [k·IN_W +: IN_W].
- Completing beat (`bcnt`=RATIO-1): the next cycle drives `de_o`=1 and the full word on `pdata_o`. `sof_o`=`sof_pend` on that cycle, and `sof_pend` then clears.
- Line end: `de_i` falls, i.e. the registered `de_i` is 1 and the current `de_i` is 0. Next cycle:
  - `eol_o`=1;
  - `line_cnt_o` increments, saturating at 2^LINE_W−1;
  - if `bcnt`≠0, `err_o`=1, the partial word is discarded and `bcnt` is cleared.
- Boundary and line end in the same cycle: the boundary wins. The partial word is dropped with no `err_o`. `eol_o` still pulses, and `line_cnt_o` is cleared rather than incremented.
- A boundary arriving while `de_i`=1 restarts packing on the next beat, which goes to slot 0.
- `pdata_o` holds its last value when `de_o`=0.

## Timing
- Latency: 1 `pclk` from the completing beat to `de_o`. Back-to-back words are possible, e.g. RATIO=2 gives at most one `de_o` every 2 cycles.
- `eol_o` and `err_o` assert 1 cycle after the first `de_i`=0 sample.
- Reset values: `de_o`, `sof_o`, `eol_o`, `err_o` = 0; `pdata_o`, `line_cnt_o`, `frame_lines_o` = 0; state IDLE; `bcnt` = 0; `swap_q` = 0; registered `vs_i`/`de_i` = 0.
- Reset asserted mid-line: the next cycle has all outputs at their reset values. No word is emitted for beats accepted before the reset.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `cmos_pkg`:
  - state enum (IDLE, RUN);
  - function `slot_lsb(k, swap, IN_W, RATIO)` returning the bit offset of slot k.
- One natural sub-module, `cmos_sync_edge`: a registered input with rise/fall pulse outputs, instantiated for `vs_i` (polarity-adjusted by `VS_POL`) and for `de_i`.
- Everything else lives in the top module.

## Test plan
- Reset, then beats with `vs_i` never toggling → `de_o` stays 0 and `line_cnt_o` stays 0 (unarmed).
- IN_W=8, RATIO=2, `swap_i`=0. Boundary, then a line of beats 0x12,0x34,0x56,0x78 → `de_o` carries 0x1234 (with `sof_o`=1), then 0x5678 (`sof_o`=0), each 1 cycle after its second beat. `eol_o` pulses and `line_cnt_o`=1.
- Same stimulus with `swap_i`=1 latched at the boundary → 0x3412, 0x7856. Toggling `swap_i` mid-frame changes nothing until the next boundary.
- RATIO=3, a line of 7 beats → 2 words emitted, then `err_o`=1 together with `eol_o`. The next line's first beat lands in slot 0.
- Frame of 4 lines, then a boundary → `frame_lines_o`=4 and `line_cnt_o`=0. Boundary coincident with a line end and a partial word → `err_o`=0 and `line_cnt_o`=0.
- `rst` pulsed high for 1 cycle mid-word → all outputs 0 and state IDLE. No word is emitted until the next boundary re-arms the block.
